// File: rtl/pll_iobuf_bank.sv
// Bidirectional pad bank: direction-turnaround FSM, registered transmit path, multi-flop receive synchronizer.
// Define PLL_IOBUF_FILTER_EN to add a per-bit glitch filter between the synchronizer and o.
module pll_iobuf_bank #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] io,
    output logic [WIDTH-1:0] o,
    output logic             drv,
    output logic             busy
);

    localparam int CNT_W = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    localparam logic [1:0] ST_RX      = 2'd0;
    localparam logic [1:0] ST_TURN_TX = 2'd1;
    localparam logic [1:0] ST_TX      = 2'd2;
    localparam logic [1:0] ST_TURN_RX = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             drv_r;
    logic             busy_r;
    logic [WIDTH-1:0] tx_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];

    // Next-state and turnaround-count logic; the counter stops at CNT_LAST so it never wraps
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RX: begin
                cnt_s = {CNT_W{1'b0}};
                if (oe) begin
                    if (TURN_CYCLES == 0) begin
                        state_s = ST_TX;
                    end else begin
                        state_s = ST_TURN_TX;
                    end
                end else begin
                    state_s = ST_RX;
                end
            end
            ST_TURN_TX: begin
                if (!oe) begin
                    state_s = ST_RX;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_TX;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_TX: begin
                cnt_s = {CNT_W{1'b0}};
                if (!oe) begin
                    if (TURN_CYCLES == 0) begin
                        state_s = ST_RX;
                    end else begin
                        state_s = ST_TURN_RX;
                    end
                end else begin
                    state_s = ST_TX;
                end
            end
            ST_TURN_RX: begin
                // Receive turnaround always runs to completion; oe is re-evaluated from RX
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_RX;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_RX;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register plus drv/busy decoded from the next state so they are registered state decodes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RX;
            cnt_r   <= {CNT_W{1'b0}};
            drv_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            drv_r   <= (state_s == ST_TX);
            busy_r  <= (state_s == ST_TURN_TX) || (state_s == ST_TURN_RX);
        end
    end

    // Transmit register samples i every cycle regardless of direction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_r <= {WIDTH{1'b0}};
        end else begin
            tx_r <= i;
        end
    end

    // Pad is never left floating: it carries zeros whenever the bank is not transmitting
    assign io   = drv_r ? tx_r : {WIDTH{1'b0}};
    assign drv  = drv_r;
    assign busy = busy_r;

    // Receive synchronizer chain, active in every state so TX loops back onto o
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= io;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

`ifdef PLL_IOBUF_FILTER_EN
    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

    logic [FC_W-1:0]  filt_cnt_r [WIDTH];
    logic [WIDTH-1:0] filt_r;

    // Per-bit filter: accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_r <= {WIDTH{1'b0}};
            for (int b = 0; b < WIDTH; b++) begin
                filt_cnt_r[b] <= {FC_W{1'b0}};
            end
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (sync_r[SYNC_STAGES-1][b] == filt_r[b]) begin
                    filt_cnt_r[b] <= {FC_W{1'b0}};
                end else if (filt_cnt_r[b] == FC_LAST) begin
                    filt_r[b]     <= sync_r[SYNC_STAGES-1][b];
                    filt_cnt_r[b] <= {FC_W{1'b0}};
                end else begin
                    filt_cnt_r[b] <= filt_cnt_r[b] + FC_W'(1'b1);
                end
            end
        end
    end

    assign o = filt_r;
`else
    assign o = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: tb/tb_pll_iobuf_bank.sv
// Directed bench for pll_iobuf_bank: expectations are queued with a due edge when stimulus is applied
// and compared once that edge has passed. The pad is a wired-OR net so an external driver can pulse it.
module tb_pll_iobuf_bank;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    localparam int SEL_IO    = 0;
    localparam int SEL_O     = 1;
    localparam int SEL_DRV   = 2;
    localparam int SEL_BUSY  = 3;
    localparam int SEL_DRV0  = 4;
    localparam int SEL_BUSY0 = 5;
    localparam int SEL_IO0   = 6;

    typedef struct {
        int               due;
        int               sel;
        logic [WIDTH-1:0] exp;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] i;
    logic             oe;
    logic             oe0;
    logic [WIDTH-1:0] ext_r;
    wor   [WIDTH-1:0] io_w;
    wire  [WIDTH-1:0] io0_w;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o0;
    logic             drv;
    logic             busy;
    logic             drv0;
    logic             busy0;

    exp_t sb_q[$];
    int   edge_n       = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    assign io_w = ext_r;

    pll_iobuf_bank #(.WIDTH(WIDTH), .TURN_CYCLES(2), .SYNC_STAGES(SYNC), .FILTER_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .oe(oe), .io(io_w), .o(o), .drv(drv), .busy(busy)
    );

    pll_iobuf_bank #(.WIDTH(WIDTH), .TURN_CYCLES(0), .SYNC_STAGES(SYNC), .FILTER_LEN(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .i(i), .oe(oe0), .io(io0_w), .o(o0), .drv(drv0), .busy(busy0)
    );

    function automatic logic [WIDTH-1:0] observe(input int sel);
        case (sel)
            SEL_IO:    return io_w;
            SEL_O:     return o;
            SEL_DRV:   return {{(WIDTH-1){1'b0}}, drv};
            SEL_BUSY:  return {{(WIDTH-1){1'b0}}, busy};
            SEL_DRV0:  return {{(WIDTH-1){1'b0}}, drv0};
            SEL_BUSY0: return {{(WIDTH-1){1'b0}}, busy0};
            SEL_IO0:   return io0_w;
            default:   return {WIDTH{1'bx}};
        endcase
    endfunction

    task automatic exp_at(input int d, input int sel, input logic [WIDTH-1:0] v, input string tag);
        exp_t e;
        e.due = edge_n + d;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic check_due();
        exp_t             keep_q[$];
        exp_t             e;
        logic [WIDTH-1:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.due <= edge_n) begin
                obs = observe(e.sel);
                tests_run++;
                assert (obs === e.exp) else begin
                    tests_failed++;
                    $error("FAIL %s at edge %0d: observed %h expected %h", e.tag, edge_n, obs, e.exp);
                end
            end else begin
                keep_q.push_back(e);
            end
        end
        sb_q = keep_q;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        check_due();
    endtask

    initial begin
        logic [WIDTH-1:0] tx_vals [3];
        logic             busy_exp [6];
        logic             drv_exp [6];
        logic [WIDTH-1:0] io_exp [6];

        tx_vals  = '{8'h5A, 8'hA5, 8'h3C};
        busy_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        drv_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        io_exp   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};

        // Reset held 3 edges with oe=1, i=FF: everything quiet
        rst_n = 1'b0;
        oe    = 1'b1;
        oe0   = 1'b0;
        i     = 8'hFF;
        ext_r = 8'h00;
        for (int k = 1; k <= 3; k++) begin
            exp_at(k, SEL_IO,   8'h00, "rst_io");
            exp_at(k, SEL_O,    8'h00, "rst_o");
            exp_at(k, SEL_DRV,  8'h00, "rst_drv");
            exp_at(k, SEL_BUSY, 8'h00, "rst_busy");
            exp_at(k, SEL_DRV0, 8'h00, "rst_drv0");
        end
        repeat (3) step();

        // Release: TURN_TX for 2 edges, drv on the third
        rst_n = 1'b1;
        exp_at(1, SEL_BUSY, 8'h01, "turn_tx_busy_a");
        exp_at(1, SEL_DRV,  8'h00, "turn_tx_drv_a");
        exp_at(2, SEL_BUSY, 8'h01, "turn_tx_busy_b");
        exp_at(2, SEL_DRV,  8'h00, "turn_tx_drv_b");
        exp_at(2, SEL_IO,   8'h00, "turn_tx_io");
        exp_at(3, SEL_DRV,  8'h01, "drv_rise");
        exp_at(3, SEL_BUSY, 8'h00, "tx_busy");
        exp_at(3, SEL_IO,   8'hFF, "tx_io_first");
`ifndef PLL_IOBUF_FILTER_EN
        exp_at(4, SEL_O, 8'h00, "o_before_sync");
        exp_at(5, SEL_O, 8'hFF, "o_loopback_ff");
`endif
        repeat (3) step();

        // TX data path: io one edge after sampling, o SYNC edges after io
        for (int k = 0; k < 3; k++) begin
            i = tx_vals[k];
            exp_at(1, SEL_IO, tx_vals[k], "tx_io");
`ifndef PLL_IOBUF_FILTER_EN
            exp_at(1 + SYNC, SEL_O, tx_vals[k], "tx_o");
`endif
            step();
        end
        repeat (2) step();

        // Turnaround: drop oe, reassert one cycle later
        oe = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_at(k + 1, SEL_BUSY, {7'd0, busy_exp[k]}, "turn_busy");
            exp_at(k + 1, SEL_DRV,  {7'd0, drv_exp[k]},  "turn_drv");
            exp_at(k + 1, SEL_IO,   io_exp[k],           "turn_io");
        end
        step();
        oe = 1'b1;
        repeat (5) step();

        // Back to RX, then a one-cycle oe request aborted during TURN_TX
        oe = 1'b0;
        repeat (3) step();
        oe = 1'b1;
        exp_at(1, SEL_BUSY, 8'h01, "abort_busy_a");
        exp_at(2, SEL_BUSY, 8'h00, "abort_busy_b");
`ifndef PLL_IOBUF_FILTER_EN
        exp_at(1, SEL_O, 8'h00, "abort_o");
`endif
        for (int k = 1; k <= 4; k++) begin
            exp_at(k, SEL_DRV, 8'h00, "abort_drv");
            exp_at(k, SEL_IO,  8'h00, "abort_io");
        end
        step();
        oe = 1'b0;
        repeat (3) step();

        // Zero-turnaround instance: drv tracks oe one edge late, busy never rises
        for (int k = 0; k < 6; k++) begin
            oe0 = ~oe0;
            exp_at(1, SEL_DRV0,  {7'd0, oe0},            "tc0_drv");
            exp_at(1, SEL_BUSY0, 8'h00,                  "tc0_busy");
            exp_at(1, SEL_IO0,   oe0 ? i : 8'h00,        "tc0_io");
            step();
        end
        oe0 = 1'b0;
        step();

`ifdef PLL_IOBUF_FILTER_EN
        // Two-cycle glitch on bit0 is rejected
        ext_r = 8'h01;
        exp_at(1, SEL_IO, 8'h01, "glitch2_io");
        for (int k = 1; k <= 6; k++) begin
            exp_at(k, SEL_O, 8'h00, "glitch2_o");
        end
        repeat (2) step();
        ext_r = 8'h00;
        repeat (4) step();
        // Three-cycle pulse passes after SYNC+3 edges
        ext_r = 8'h01;
        exp_at(SYNC + 2, SEL_O, 8'h00, "pulse3_o_early");
        exp_at(SYNC + 3, SEL_O, 8'h01, "pulse3_o");
        repeat (3) step();
        ext_r = 8'h00;
        repeat (3) step();
`else
        // Unfiltered: a single-cycle pulse on bit0 reaches o after SYNC edges
        ext_r = 8'h01;
        exp_at(1, SEL_IO, 8'h01, "pulse1_io");
        exp_at(1, SEL_O,  8'h00, "pulse1_o_early");
        exp_at(2, SEL_O,  8'h01, "pulse1_o");
        exp_at(3, SEL_O,  8'h00, "pulse1_o_after");
        step();
        ext_r = 8'h00;
        repeat (3) step();
`endif

        repeat (2) step();
        tests_run++;
        assert (sb_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
